// File: rtl/gate_arb_pkg.sv
// Shared definitions for the gate-sharing arbiter tile: gate opcodes, FSM states,
// requester count and the bit positions of the fields packed onto the tile pins.
// No logic of its own apart from the gate evaluation helper.
package gate_arb_pkg;

  localparam int NREQ = 4;

  // Gate opcodes carried on ui_in[5:4]
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_GRANT    = 2'b01,
    ST_COOLDOWN = 2'b10
  } state_t;

  // ui_in field positions
  localparam int UI_REQ_LSB = 0;
  localparam int UI_OP_LSB  = 4;
  localparam int UI_PTR_CLR = 6;
  localparam int UI_PAUSE   = 7;

  // uo_out field positions
  localparam int UO_GRANT_LSB = 0;
  localparam int UO_RESULT    = 4;
  localparam int UO_VALID     = 5;
  localparam int UO_INDEX_LSB = 6;

  function automatic logic gate_eval(input logic [1:0] op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set request scanning ptr, ptr+1, ... mod 4.
// Latency: purely combinational. Backpressure: none (no storage).
// Ports: req[3:0] requests, ptr[1:0] highest-priority slot; any = some request, sel = winner.
module rr_pick4
  import gate_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic            any,
  output logic [1:0]      sel
);

  logic [1:0] idx;

  // Walk from the lowest-priority offset up so the nearest set request wins last.
  always_comb begin
    sel = ptr;
    idx = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      idx = ptr + 2'(j);
      if (req[idx]) sel = idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/tt_um_gate_share_arbiter.sv
// Round-robin sharing of one registered 2-input gate among 4 requesters (Tiny Tapeout tile).
// Latency: grant one edge after req is seen in IDLE, first result one edge later.
// Backpressure: pause (ui_in[7]) or ena=0 freezes all state and forces result_valid low.
// Ports: ui_in = {pause, ptr_clr, op[1:0], req[3:0]}; uio_in = operand pairs {b3,a3,..,b0,a0};
//        uo_out = {index[1:0], valid, result, grant[3:0]}; uio_out/uio_oe tied to 0.
module tt_um_gate_share_arbiter
  import gate_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam logic [3:0] CNT_MAX = 4'(MAX_HOLD - 1);

  logic [NREQ-1:0] req;
  logic [1:0]      op;
  logic            ptr_clr;
  logic            frozen;

  assign req     = ui_in[UI_REQ_LSB +: NREQ];
  assign op      = ui_in[UI_OP_LSB +: 2];
  assign ptr_clr = ui_in[UI_PTR_CLR];
  assign frozen  = ui_in[UI_PAUSE] | ~ena;

  state_t          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [1:0]      index_q, index_d;
  logic            result_q, result_d;
  logic            valid_q, valid_d;

  logic       pick_any;
  logic [1:0] pick_sel;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .sel (pick_sel)
  );

  logic a_g, b_g, timeout;

  assign a_g = uio_in[{index_q, 1'b0}];
  assign b_g = uio_in[{index_q, 1'b1}];
  // Tenure ends on a saturated counter only if someone else is actually waiting.
  assign timeout = (cnt_q == CNT_MAX) && |(req & ~grant_q);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    index_d  = index_q;
    result_d = result_q;
    valid_d  = 1'b0;
    if (!frozen) begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_d           = '0;
            grant_d[pick_sel] = 1'b1;
            index_d           = pick_sel;
            cnt_d             = '0;
            state_d           = ST_GRANT;
          end
        end
        ST_GRANT: begin
          result_d = gate_eval(op, a_g, b_g);
          valid_d  = 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 4'd1;
          if (!req[index_q] || timeout) state_d = ST_COOLDOWN;
        end
        ST_COOLDOWN: begin
          grant_d = '0;
          ptr_d   = index_q + 2'd1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Clear wins over the cooldown rotation; same-edge arbitration already used ptr_q.
    if (ptr_clr) ptr_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      index_q  <= '0;
      result_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      index_q  <= index_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    uo_out = '0;
    uo_out[UO_GRANT_LSB +: NREQ] = grant_q;
    uo_out[UO_RESULT]            = result_q;
    uo_out[UO_VALID]             = valid_q;
    uo_out[UO_INDEX_LSB +: 2]    = index_q;
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_gate_share_arbiter.sv
module tb_tt_um_gate_share_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] req;
  logic [1:0] op;
  logic       clr;
  logic       pause;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  assign ui_in = {pause, clr, op, req};

  tt_um_gate_share_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the gate, how many results it has produced, whether
  // it is cooling down, and the rotation pointer. Expected pins follow from that.
  int         m_phase;   // 0 free, 1 owned, 2 cooling down
  int         m_owner;
  int         m_served;
  int         m_ptr;
  logic [3:0] e_grant;
  logic [1:0] e_index;
  logic       e_result;
  logic       e_valid;

  function automatic logic gate(input logic [1:0] o, input logic a, input logic b);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return !a;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_served = 0; m_ptr = 0;
    e_grant = 4'b0; e_index = 2'b0; e_result = 1'b0; e_valid = 1'b0;
  endtask

  // Called just before an edge with the inputs that edge will see.
  task automatic model_edge();
    int         sel;
    logic [3:0] others;
    if (!pause && ena) begin
      if (m_phase == 0) begin
        e_valid = 1'b0;
        sel = -1;
        for (int j = 0; j < 4; j++)
          if (sel < 0 && req[(m_ptr + j) % 4]) sel = (m_ptr + j) % 4;
        if (sel >= 0) begin
          m_owner = sel; m_served = 0; m_phase = 1;
          e_grant = 4'(1 << sel); e_index = 2'(sel);
        end
      end else if (m_phase == 1) begin
        e_result = gate(op, uio_in[2*m_owner], uio_in[2*m_owner+1]);
        e_valid  = 1'b1;
        others = req;
        others[m_owner] = 1'b0;
        if (!req[m_owner] || (m_served >= MAX_HOLD - 1 && others != 4'b0)) m_phase = 2;
        m_served++;
      end else begin
        e_grant = 4'b0; e_valid = 1'b0;
        m_ptr = (m_owner + 1) % 4;
        m_phase = 0;
      end
    end else begin
      e_valid = 1'b0;
    end
    if (clr) m_ptr = 0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      model_edge();
      @(posedge clk);
      #1;
      check("model_uo", uo_out, {e_index, e_valid, e_result, e_grant});
    end
  endtask

  // Entered 1 time unit after an edge: reset must clear outputs before the next edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check("reset_uo", uo_out, 8'h00);
    check("reset_uio", {uio_oe, uio_out}, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [1:0] op;
    logic [7:0] uio;
    logic       pause;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[14];
  logic [7:0] lg[60];

  initial begin
    int nrun, cur, gapc, cnt, hold;
    int r_idx[16], r_len[16], r_gap[16];

    // Hand-derived: uo_out = {index, valid, result, grant}
    vt[0]  = '{4'b0001, 2'b00, 8'h03, 1'b0, 8'h01}; // grant 0 appears
    vt[1]  = '{4'b0001, 2'b00, 8'h03, 1'b0, 8'h31}; // AND(1,1)=1
    vt[2]  = '{4'b0001, 2'b00, 8'h01, 1'b0, 8'h21}; // AND(1,0)=0
    vt[3]  = '{4'b0001, 2'b01, 8'h01, 1'b0, 8'h31}; // OR(1,0)=1
    vt[4]  = '{4'b0000, 2'b01, 8'h00, 1'b0, 8'h21}; // drop: last result, go cooldown
    vt[5]  = '{4'b0000, 2'b01, 8'h00, 1'b0, 8'h00}; // cooldown, ptr -> 1
    vt[6]  = '{4'b0010, 2'b10, 8'h0C, 1'b0, 8'h42}; // grant requester 1
    vt[7]  = '{4'b0010, 2'b10, 8'h0C, 1'b0, 8'h62}; // XOR(1,1)=0
    vt[8]  = '{4'b0010, 2'b10, 8'h04, 1'b0, 8'h72}; // XOR(1,0)=1
    vt[9]  = '{4'b0010, 2'b11, 8'h08, 1'b0, 8'h72}; // NOT a=0 -> 1
    vt[10] = '{4'b0010, 2'b11, 8'h04, 1'b0, 8'h62}; // NOT a=1 -> 0
    vt[11] = '{4'b0010, 2'b11, 8'h08, 1'b1, 8'h42}; // paused: hold, valid low
    vt[12] = '{4'b0000, 2'b11, 8'h04, 1'b0, 8'h62}; // drop acted on after release
    vt[13] = '{4'b0000, 2'b11, 8'h04, 1'b0, 8'h40}; // cooldown, index held

    rst_n = 1'b1; ena = 1'b1; req = 4'b0; op = 2'b0; clr = 1'b0; pause = 1'b0; uio_in = 8'h00;
    model_reset();
    #6;
    do_reset();

    for (int i = 0; i < 14; i++) begin
      req = vt[i].req; op = vt[i].op; uio_in = vt[i].uio; pause = vt[i].pause;
      step(1);
      check($sformatf("vec%0d", i), uo_out, vt[i].exp);
    end
    pause = 1'b0;

    // All four requesting: rotation 0,1,2,3,0, MAX_HOLD results each, 2 idle-valid cycles between.
    do_reset();
    req = 4'b1111; op = 2'b00; uio_in = 8'hFF;
    for (int i = 0; i < 60; i++) begin
      step(1);
      lg[i] = uo_out;
    end
    nrun = 0; cur = 0; gapc = 0;
    for (int i = 0; i < 16; i++) begin r_idx[i] = -1; r_len[i] = 0; r_gap[i] = -1; end
    for (int i = 0; i < 60; i++) begin
      if (lg[i][5]) begin
        if (cur == 0 && nrun < 16) begin r_idx[nrun] = int'(lg[i][7:6]); r_gap[nrun] = gapc; end
        cur++; gapc = 0;
      end else begin
        if (cur > 0) begin
          if (nrun < 16) r_len[nrun] = cur;
          nrun++; cur = 0;
        end
        gapc++;
      end
    end
    check("rr_run_count_ge5", 32'(nrun >= 5), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr_order%0d", k), r_idx[k], k % 4);
      check($sformatf("rr_len%0d", k), r_len[k], MAX_HOLD);
      if (k > 0) check($sformatf("rr_gap%0d", k), r_gap[k], 2);
    end

    // Lone requester 2: unbounded tenure; then a competitor takes over promptly since cnt is saturated.
    do_reset();
    req = 4'b0100;
    hold = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (uo_out[3:0] == 4'b0100) hold++;
    end
    check("lone_hold_50", hold, 50);
    req = 4'b0101;
    cnt = 0;
    while (uo_out[3:0] != 4'b0001 && cnt < 20) begin
      step(1);
      cnt++;
    end
    check("handover_cycles", cnt, 3);

    // Pause mid-tenure: valid drops, grant holds, remaining tenure is MAX_HOLD - cnt_at_pause.
    do_reset();
    req = 4'b0011;
    step(4);                     // grant + 3 results -> cnt = 3
    pause = 1'b1;
    hold = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (uo_out[5] == 1'b0 && uo_out[3:0] == 4'b0001) hold++;
    end
    check("pause_frozen", hold, 5);
    pause = 1'b0;
    cnt = 0;
    hold = 0;
    do begin
      step(1);
      if (uo_out[5]) cnt++;
      hold++;
    end while (uo_out[5] && hold < 20);
    check("pause_remaining", cnt, MAX_HOLD - 3);

    // ptr_clr on the cooldown edge overrides the rotation.
    do_reset();
    req = 4'b0001;
    step(2);
    req = 4'b0000;
    step(1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    req = 4'b0011;
    step(1);
    check("clr_overrides_cooldown", uo_out[3:0], 4'b0001);

    // Asynchronous reset in the middle of a tenure, then first arbitration from ptr 0.
    check("pre_reset_grant", uo_out[3:0], 4'b0001);
    do_reset();
    clr = 1'b1;
    req = 4'b1010;
    step(1);
    clr = 1'b0;
    check("first_after_reset", uo_out[7:0], 8'h42);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      op     = 2'($urandom_range(0, 3));
      uio_in = 8'($urandom_range(0, 255));
      pause  = ($urandom_range(0, 7) == 0);
      ena    = ($urandom_range(0, 15) != 0);
      clr    = ($urandom_range(0, 15) == 0);
      step(1);
    end
    ena = 1'b1; pause = 1'b0; clr = 1'b0;
    check("uio_zero_end", {uio_oe, uio_out}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
